// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_pkg
// Description : Opcode, state-encoding and result-width definitions shared by
//               the calculator ALU sequencer and its divider.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_XOR  = 3'b100;
    localparam logic [2:0] c_OP_MUL  = 3'b101;
    localparam logic [2:0] c_OP_DIV  = 3'b110;
    localparam logic [2:0] c_OP_PASS = 3'b111;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LOAD = 3'd1;
    localparam logic [2:0] c_ST_MUL  = 3'd2;
    localparam logic [2:0] c_ST_DIV  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    function automatic int calc_res_width(input int width);
        return 2 * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Restoring-divide working registers; one quotient bit per step.
//               Next-step quotient/remainder are exposed so the sequencer can
//               capture the final step without an extra cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_finish,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_quo_nxt,
    output logic [WIDTH-1:0] o_rem_nxt
);

    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    // The partial remainder is always below the divisor, so the shifted value
    // fits WIDTH+1 bits and the restored result fits WIDTH bits.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_dvs});
    assign w_diff    = w_shift - {1'b0, r_dvs};
    assign o_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (i_start) begin
            r_quo <= i_dividend;
            r_rem <= '0;
            r_dvs <= i_divisor;
        end else if (i_finish) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dvs <= '0;
        end else if (i_step) begin
            r_quo <= o_quo_nxt;
            r_rem <= o_rem_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calc_sequencer
// Description : Multi-cycle ALU sequencer (single-cycle ops, shift-add
//               multiply, restoring divide). Divider built only when
//               CALC_SEQ_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                                CLK,
    input  logic                                clear,
    input  logic                                start,
    input  logic [2:0]                          MS,
    input  logic [WIDTH-1:0]                    A,
    input  logic [WIDTH-1:0]                    B,
    output logic                                busy,
    output logic                                done,
    output logic [calc_res_width(WIDTH)-1:0]    result,
    output logic                                div_err
);

    localparam int              c_RW   = calc_res_width(WIDTH);
    localparam int              c_CW   = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    logic [2:0]       r_state, w_state_nxt;
    logic             r_start_q, r_req;
    logic [WIDTH-1:0] r_a, r_b, w_a_nxt, w_b_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic [c_CW-1:0]  r_cnt, w_cnt_nxt;
    logic [c_RW-1:0]  r_acc, w_acc_nxt, w_mul_nxt;
    logic [c_RW-1:0]  r_result, w_result_nxt;
    logic             r_div_err, w_err_nxt;
    logic             r_busy, r_done;
    logic [WIDTH:0]   w_sum;

    // Accumulator holds {partial product, remaining multiplier bits}.
    assign w_sum     = {1'b0, r_acc[c_RW-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

`ifdef CALC_SEQ_DIV_EN
    logic             w_div_start, w_div_step, w_div_finish;
    logic [WIDTH-1:0] w_quo_nxt, w_rem_nxt;

    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk        (CLK),
        .rst        (clear),
        .i_start    (w_div_start),
        .i_step     (w_div_step),
        .i_finish   (w_div_finish),
        .i_dividend (r_a),
        .i_divisor  (r_b),
        .o_quo_nxt  (w_quo_nxt),
        .o_rem_nxt  (w_rem_nxt)
    );
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_cnt_nxt    = '0;
        w_acc_nxt    = r_acc;
        w_result_nxt = r_result;
        w_err_nxt    = r_div_err;
`ifdef CALC_SEQ_DIV_EN
        w_div_start  = 1'b0;
        w_div_step   = 1'b0;
        w_div_finish = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE, c_ST_DONE: begin
                if (r_req) begin
                    w_state_nxt  = c_ST_LOAD;
                    w_a_nxt      = A;
                    w_b_nxt      = B;
                    w_op_nxt     = MS;
                    w_result_nxt = '0;
                    w_err_nxt    = 1'b0;
                end
            end
            c_ST_LOAD: begin
                w_state_nxt = c_ST_DONE;
                case (r_op)
                    c_OP_ADD:  w_result_nxt = {{(WIDTH-1){1'b0}}, {1'b0, r_a} + {1'b0, r_b}};
                    c_OP_SUB:  w_result_nxt = {{WIDTH{1'b0}}, r_a} - {{WIDTH{1'b0}}, r_b};
                    c_OP_AND:  w_result_nxt = {{WIDTH{1'b0}}, r_a & r_b};
                    c_OP_OR:   w_result_nxt = {{WIDTH{1'b0}}, r_a | r_b};
                    c_OP_XOR:  w_result_nxt = {{WIDTH{1'b0}}, r_a ^ r_b};
                    c_OP_MUL: begin
                        w_acc_nxt   = {{WIDTH{1'b0}}, r_a};
                        w_state_nxt = c_ST_MUL;
                    end
                    c_OP_DIV: begin
`ifdef CALC_SEQ_DIV_EN
                        if (r_b == '0) begin
                            w_result_nxt = {r_a, {WIDTH{1'b1}}};
                            w_err_nxt    = 1'b1;
                        end else begin
                            w_div_start = 1'b1;
                            w_state_nxt = c_ST_DIV;
                        end
`else
                        w_result_nxt = '0;
                        w_err_nxt    = 1'b1;
`endif
                    end
                    default:   w_result_nxt = {{WIDTH{1'b0}}, r_a};
                endcase
            end
            c_ST_MUL: begin
                w_acc_nxt = w_mul_nxt;
                if (r_cnt == c_LAST) begin
                    w_result_nxt = w_mul_nxt;
                    w_state_nxt  = c_ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
`ifdef CALC_SEQ_DIV_EN
            c_ST_DIV: begin
                w_div_step = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_result_nxt = {w_rem_nxt, w_quo_nxt};
                    w_div_finish = 1'b1;
                    w_state_nxt  = c_ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CW'(1);
                end
            end
`endif
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // start_q resets high so a start held across reset release is not a request.
    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            r_state   <= c_ST_IDLE;
            r_start_q <= 1'b1;
            r_req     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= c_OP_ADD;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_div_err <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_start_q <= start;
            r_req     <= start & ~r_start_q;
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_op      <= w_op_nxt;
            r_cnt     <= w_cnt_nxt;
            r_acc     <= w_acc_nxt;
            r_result  <= w_result_nxt;
            r_div_err <= w_err_nxt;
            r_busy    <= (w_state_nxt == c_ST_LOAD) || (w_state_nxt == c_ST_MUL) ||
                         (w_state_nxt == c_ST_DIV);
            r_done    <= (w_state_nxt == c_ST_DONE);
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign div_err = r_div_err;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_sequencer
// Description : Directed self-checking bench for calc_sequencer (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_sequencer;
    import calc_pkg::*;

    localparam int WIDTH = 8;

    logic             CLK   = 1'b0;
    logic             clear = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       MS    = 3'b000;
    logic [WIDTH-1:0] A     = '0;
    logic [WIDTH-1:0] B     = '0;
    logic             busy, done, div_err;
    logic [2*WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;

    calc_sequencer #(.WIDTH(WIDTH)) dut (
        .CLK     (CLK),
        .clear   (clear),
        .start   (start),
        .MS      (MS),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .div_err (div_err)
    );

    always #5 CLK = ~CLK;

    // Leaves the caller at the negedge following the edge that samples the request.
    task automatic request(input logic [7:0] a, input logic [7:0] b, input logic [2:0] ms);
        @(negedge CLK);
        A = a; B = b; MS = ms; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({busy, done, div_err, result} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs got b=%0b d=%0b e=%0b r=%h want all zero", busy, done, div_err, result);
        end
        clear = 1'b0;
        @(negedge CLK);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_release got b=%0b d=%0b want 0 0", busy, done);
        end
    endtask

    task automatic test_add();
        request(8'd200, 8'd100, c_OP_ADD);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL add_k0 got b=%0b d=%0b want 0 0", busy, done);
        end
        @(negedge CLK);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL add_k1 got b=%0b d=%0b want 1 0", busy, done);
        end
        @(negedge CLK);
        checks++;
        if ({busy, done, div_err, result} !== {3'b010, 16'h012C}) begin
            errors++;
            $display("FAIL add_k2 got b=%0b d=%0b e=%0b r=%h want 0 1 0 012c", busy, done, div_err, result);
        end
    endtask

    task automatic test_single_ops();
        logic [7:0]  a_t [5] = '{8'd3, 8'hF0, 8'hF0, 8'hAA, 8'h5A};
        logic [7:0]  b_t [5] = '{8'd5, 8'h3C, 8'h0F, 8'hFF, 8'h77};
        logic [2:0]  o_t [5] = '{c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_PASS};
        logic [15:0] e_t [5] = '{16'hFFFE, 16'h0030, 16'h00FF, 16'h0055, 16'h005A};
        for (int i = 0; i < 5; i++) begin
            request(a_t[i], b_t[i], o_t[i]);
            checks++;
            if ({busy, done} !== 2'b01) begin
                errors++;
                $display("FAIL op%0d_k0_still_done got b=%0b d=%0b want 0 1", i, busy, done);
            end
            @(negedge CLK);
            checks++;
            if ({busy, done, div_err, result} !== {3'b100, 16'h0000}) begin
                errors++;
                $display("FAIL op%0d_k1_restart got b=%0b d=%0b e=%0b r=%h want 1 0 0 0000", i, busy, done, div_err, result);
            end
            @(negedge CLK);
            checks++;
            if ({busy, done, div_err, result} !== {3'b010, e_t[i]}) begin
                errors++;
                $display("FAIL op%0d_k2 got b=%0b d=%0b e=%0b r=%h want 0 1 0 %h", i, busy, done, div_err, result, e_t[i]);
            end
        end
    endtask

    task automatic test_mul();
        request(8'd255, 8'd255, c_OP_MUL);
        for (int j = 1; j <= 9; j++) begin
            @(negedge CLK);
            checks++;
            if ({busy, done} !== 2'b10) begin
                errors++;
                $display("FAIL mul_busy_k%0d got b=%0b d=%0b want 1 0", j, busy, done);
            end
        end
        @(negedge CLK);
        checks++;
        if ({busy, done, div_err, result} !== {3'b010, 16'hFE01}) begin
            errors++;
            $display("FAIL mul_k10 got b=%0b d=%0b e=%0b r=%h want 0 1 0 fe01", busy, done, div_err, result);
        end
    endtask

    task automatic test_mul_ignore();
        request(8'd255, 8'd255, c_OP_MUL);
        repeat (5) @(negedge CLK);
        A = 8'd1; B = 8'd1; MS = c_OP_ADD; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        checks++;
        if ({busy, done, div_err, result} !== {3'b010, 16'hFE01}) begin
            errors++;
            $display("FAIL mul_ignore_k10 got b=%0b d=%0b e=%0b r=%h want 0 1 0 fe01", busy, done, div_err, result);
        end
        repeat (3) @(negedge CLK);
        checks++;
        if ({busy, done, div_err, result} !== {3'b010, 16'hFE01}) begin
            errors++;
            $display("FAIL mul_ignore_hold got b=%0b d=%0b e=%0b r=%h want 0 1 0 fe01", busy, done, div_err, result);
        end
    endtask

    task automatic test_div();
        request(8'd200, 8'd7, c_OP_DIV);
`ifdef CALC_SEQ_DIV_EN
        repeat (9) @(negedge CLK);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL div_k9 got b=%0b d=%0b want 1 0", busy, done);
        end
        @(negedge CLK);
        checks++;
        if ({busy, done, div_err, result} !== {3'b010, 16'h041C}) begin
            errors++;
            $display("FAIL div_k10 got b=%0b d=%0b e=%0b r=%h want 0 1 0 041c", busy, done, div_err, result);
        end
`else
        repeat (2) @(negedge CLK);
        checks++;
        if ({busy, done, div_err, result} !== {3'b011, 16'h0000}) begin
            errors++;
            $display("FAIL div_nodiv_k2 got b=%0b d=%0b e=%0b r=%h want 0 1 1 0000", busy, done, div_err, result);
        end
`endif
    endtask

    task automatic test_div_zero();
        logic [15:0] exp_r;
`ifdef CALC_SEQ_DIV_EN
        exp_r = 16'h09FF;
`else
        exp_r = 16'h0000;
`endif
        request(8'd9, 8'd0, c_OP_DIV);
        @(negedge CLK);
        checks++;
        if ({busy, done, div_err, result} !== {3'b100, 16'h0000}) begin
            errors++;
            $display("FAIL divz_k1 got b=%0b d=%0b e=%0b r=%h want 1 0 0 0000", busy, done, div_err, result);
        end
        @(negedge CLK);
        checks++;
        if ({busy, done, div_err, result} !== {3'b011, exp_r}) begin
            errors++;
            $display("FAIL divz_k2 got b=%0b d=%0b e=%0b r=%h want 0 1 1 %h", busy, done, div_err, result, exp_r);
        end
    endtask

    task automatic test_clear_abort();
`ifdef CALC_SEQ_DIV_EN
        request(8'd200, 8'd7, c_OP_DIV);
`else
        request(8'd200, 8'd7, c_OP_MUL);
`endif
        repeat (6) @(negedge CLK);
        checks++;
        if ({busy, done} !== 2'b10) begin
            errors++;
            $display("FAIL abort_pre got b=%0b d=%0b want 1 0", busy, done);
        end
        #2 clear = 1'b1;
        #1;
        checks++;
        if ({busy, done, div_err, result} !== 19'd0) begin
            errors++;
            $display("FAIL abort_async got b=%0b d=%0b e=%0b r=%h want all zero", busy, done, div_err, result);
        end
        @(negedge CLK);
        clear = 1'b0;
        repeat (12) @(negedge CLK);
        checks++;
        if ({busy, done, div_err, result} !== 19'd0) begin
            errors++;
            $display("FAIL abort_idle got b=%0b d=%0b e=%0b r=%h want all zero", busy, done, div_err, result);
        end
    endtask

    task automatic test_start_held();
        @(negedge CLK);
        clear = 1'b1; start = 1'b1; A = 8'd1; B = 8'd2; MS = c_OP_ADD;
        @(negedge CLK);
        clear = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge CLK);
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL held_start_c%0d got b=%0b d=%0b want 0 0", j, busy, done);
            end
        end
        start = 1'b0;
        request(8'd1, 8'd2, c_OP_ADD);
        repeat (2) @(negedge CLK);
        checks++;
        if ({busy, done, div_err, result} !== {3'b010, 16'h0003}) begin
            errors++;
            $display("FAIL held_start_toggle got b=%0b d=%0b e=%0b r=%h want 0 1 0 0003", busy, done, div_err, result);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_single_ops();
        test_mul();
        test_mul_ignore();
        test_div();
        test_div_zero();
        test_clear_abort();
        test_start_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
